// File: rtl/lu_share_arbiter_if.sv
// Bundles the two requester channels, the shared logic-unit channel and the response channel.
interface lu_share_arbiter_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [N-1:0]     req0_c;
    logic [N-1:0]     req0_d;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [N-1:0]     req1_c;
    logic [N-1:0]     req1_d;
    logic [1:0]       req1_op;

    logic [N-1:0]     lu_c;
    logic [N-1:0]     lu_d;
    logic [1:0]       lu_op;
    logic [N-1:0]     lu_f;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_f;
    logic             rsp_id;
    logic [CNT_W-1:0] done_cnt;

    modport slave (
        input  req0_valid, req0_c, req0_d, req0_op,
        output req0_ready,
        input  req1_valid, req1_c, req1_d, req1_op,
        output req1_ready,
        output lu_c, lu_d, lu_op,
        input  lu_f,
        output rsp_valid, rsp_f, rsp_id, done_cnt,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_c, req0_d, req0_op,
        input  req0_ready,
        output req1_valid, req1_c, req1_d, req1_op,
        input  req1_ready,
        input  lu_c, lu_d, lu_op,
        output lu_f,
        input  rsp_valid, rsp_f, rsp_id, done_cnt,
        output rsp_ready
    );
endinterface

// File: rtl/lu_share_arbiter.sv
// Round-robin share of one combinational logic unit between two requesters.
// Response valid two edges after acceptance; both requesters are blocked until the response handshakes.
module lu_share_arbiter #(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    lu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic             last_grant;
    logic             grant;
    logic             any_vld;
    logic [N-1:0]     c_q;
    logic [N-1:0]     d_q;
    logic [1:0]       op_q;
    logic [N-1:0]     rsp_f_q;
    logic             rsp_id_q;
    logic [CNT_W-1:0] done_q;

    // With both pending, the requester that did not win last time takes the grant.
    assign any_vld = bus.req0_valid | bus.req1_valid;
    assign grant   = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_vld)       state_nx = EXEC;
            EXEC:                       state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.lu_c       = '0;
        bus.lu_d       = '0;
        bus.lu_op      = '0;
        bus.rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && any_vld) begin
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                end
            end
            EXEC: begin
                bus.lu_c  = c_q;
                bus.lu_d  = d_q;
                bus.lu_op = op_q;
            end
            RESP: begin
                bus.lu_c      = c_q;
                bus.lu_d      = d_q;
                bus.lu_op     = op_q;
                bus.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            c_q        <= '0;
            d_q        <= '0;
            op_q       <= '0;
            rsp_f_q    <= '0;
            rsp_id_q   <= 1'b0;
            done_q     <= '0;
        end else begin
            if (state == IDLE && any_vld) begin
                c_q        <= grant ? bus.req1_c  : bus.req0_c;
                d_q        <= grant ? bus.req1_d  : bus.req0_d;
                op_q       <= grant ? bus.req1_op : bus.req0_op;
                rsp_id_q   <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                rsp_f_q <= bus.lu_f;
            end
            if (state == RESP && bus.rsp_ready && done_q != '1) begin
                done_q <= done_q + 1'b1;
            end
        end
    end

    assign bus.rsp_f    = rsp_f_q;
    assign bus.rsp_id   = rsp_id_q;
    assign bus.done_cnt = done_q;

endmodule

// File: tb/tb_lu_share_arbiter.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, randomized traffic vs a grant/result model.
module tb_lu_share_arbiter;
    localparam int N        = 2;
    localparam int CNT_W    = 8;
    localparam int DONE_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lu_share_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();

    lu_share_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lu_model(input logic [N-1:0] c, input logic [N-1:0] d,
                                              input logic [1:0] op);
        case (op)
            2'd0:    return ~c & d;
            2'd1:    return ~c | d;
            2'd2:    return ~c & d;
            default: return ~c;
        endcase
    endfunction

    assign bus.lu_f = lu_model(bus.lu_c, bus.lu_d, bus.lu_op);

    int n_checks;
    int n_fail;
    int m_last;
    int m_done;

    function automatic int m_grant(input bit v0, input bit v1);
        if (v0 && v1) return 1 - m_last;
        if (v0)       return 0;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE with rsp_ready high; exp_id/exp_f come from the caller.
    task automatic txn(input bit v0, input bit v1,
                       input logic [N-1:0] c0, input logic [N-1:0] d0, input logic [1:0] o0,
                       input logic [N-1:0] c1, input logic [N-1:0] d1, input logic [1:0] o1,
                       input int exp_id, input logic [N-1:0] exp_f);
        bus.req0_valid = v0; bus.req0_c = c0; bus.req0_d = d0; bus.req0_op = o0;
        bus.req1_valid = v1; bus.req1_c = c1; bus.req1_d = d1; bus.req1_op = o1;
        bus.rsp_ready  = 1'b1;
        #1;
        check("idle_ready0", bus.req0_ready, exp_id == 0);
        check("idle_ready1", bus.req1_ready, exp_id == 1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
        check("exec_lu_c", bus.lu_c, exp_id ? c1 : c0);
        check("exec_lu_d", bus.lu_d, exp_id ? d1 : d0);
        check("exec_lu_op", bus.lu_op, exp_id ? o1 : o0);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        step();
        check("resp_valid", bus.rsp_valid, 1);
        check("resp_f", bus.rsp_f, exp_f);
        check("resp_id", bus.rsp_id, exp_id);
        step();
        m_done = (m_done < DONE_MAX) ? m_done + 1 : DONE_MAX;
        m_last = exp_id;
        check("done_cnt", bus.done_cnt, m_done);
        check("post_rsp_valid", bus.rsp_valid, 0);
    endtask

    typedef struct {
        bit         v0, v1;
        logic [1:0] c0, d0, o0;
        logic [1:0] c1, d1, o1;
        int         exp_id;
        logic [1:0] exp_f;
    } vec_t;

    vec_t tab[8];

    bit         rv0, rv1;
    logic [1:0] rc0, rd0, ro0, rc1, rd1, ro1;
    int         g;

    initial begin
        n_checks = 0; n_fail = 0; m_last = 1; m_done = 0;
        bus.req0_valid = 1'b1; bus.req0_c = '0; bus.req0_d = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_c = '0; bus.req1_d = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b0;

        tab[0] = '{1, 0, 2'b01, 2'b11, 2'd0, 2'b00, 2'b00, 2'd0, 0, 2'b10};
        tab[1] = '{0, 1, 2'b00, 2'b00, 2'd0, 2'b10, 2'b01, 2'd2, 1, 2'b01};
        tab[2] = '{1, 1, 2'b00, 2'b00, 2'd1, 2'b11, 2'b11, 2'd3, 0, 2'b11};
        tab[3] = '{1, 1, 2'b01, 2'b01, 2'd0, 2'b11, 2'b00, 2'd3, 1, 2'b00};
        tab[4] = '{1, 0, 2'b10, 2'b01, 2'd1, 2'b00, 2'b00, 2'd0, 0, 2'b01};
        tab[5] = '{1, 1, 2'b11, 2'b11, 2'd3, 2'b00, 2'b10, 2'd0, 1, 2'b10};
        tab[6] = '{0, 1, 2'b00, 2'b00, 2'd0, 2'b01, 2'b01, 2'd1, 1, 2'b11};
        tab[7] = '{1, 1, 2'b11, 2'b10, 2'd2, 2'b01, 2'b10, 2'd1, 0, 2'b00};

        // Reset state, with req0 already valid to show ready is held off by rst.
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_f", bus.rsp_f, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_done_cnt", bus.done_cnt, 0);
        check("rst_lu_c", bus.lu_c, 0);
        step(); step();
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_no_valid_ready0", bus.req0_ready, 0);

        for (int i = 0; i < 8; i++) begin
            txn(tab[i].v0, tab[i].v1, tab[i].c0, tab[i].d0, tab[i].o0,
                tab[i].c1, tab[i].d1, tab[i].o1, tab[i].exp_id, tab[i].exp_f);
        end

        // Backpressure: response held 5 cycles while req1 waits.
        bus.req0_valid = 1'b1; bus.req0_c = 2'b01; bus.req0_d = 2'b11; bus.req0_op = 2'd0;
        bus.rsp_ready  = 1'b0;
        #1;
        check("bp_ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_c = 2'b10; bus.req1_d = 2'b00; bus.req1_op = 2'd1;
        #1;
        check("bp_exec_ready1", bus.req1_ready, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_f", bus.rsp_f, 2'b10);
            check("bp_rsp_id", bus.rsp_id, 0);
            check("bp_ready1", bus.req1_ready, 0);
            if (k < 4) step();
        end
        bus.rsp_ready = 1'b1;
        step();
        m_done = (m_done < DONE_MAX) ? m_done + 1 : DONE_MAX;
        m_last = 0;
        check("bp_done_cnt", bus.done_cnt, m_done);
        check("bp_after_ready1", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        #1;
        check("bp_req1_lu_c", bus.lu_c, 2'b10);
        check("bp_req1_lu_op", bus.lu_op, 2'd1);
        step();
        check("bp_req1_f", bus.rsp_f, 2'b01);
        check("bp_req1_id", bus.rsp_id, 1);
        step();
        m_done = (m_done < DONE_MAX) ? m_done + 1 : DONE_MAX;
        m_last = 1;
        check("bp_req1_done", bus.done_cnt, m_done);

        // Randomized traffic against the grant/result model.
        for (int i = 0; i < 40; i++) begin
            rv0 = 1'($urandom_range(0, 1)); rv1 = 1'($urandom_range(0, 1));
            rc0 = 2'($urandom); rd0 = 2'($urandom); ro0 = 2'($urandom);
            rc1 = 2'($urandom); rd1 = 2'($urandom); ro1 = 2'($urandom);
            if (!rv0 && !rv1) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
                #1;
                check("rnd_idle_ready", {bus.req0_ready, bus.req1_ready}, 0);
                step();
            end else begin
                g = m_grant(rv0, rv1);
                txn(rv0, rv1, rc0, rd0, ro0, rc1, rd1, ro1, g,
                    g ? lu_model(rc1, rd1, ro1) : lu_model(rc0, rd0, ro0));
            end
        end

        // Reset during EXEC drops the transaction and restores req0 priority.
        bus.req0_valid = 1'b1; bus.req0_c = 2'b11; bus.req0_d = 2'b11; bus.req0_op = 2'd3;
        bus.rsp_ready  = 1'b1;
        step();
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_rsp_f", bus.rsp_f, 0);
        check("mid_rst_rsp_id", bus.rsp_id, 0);
        check("mid_rst_done", bus.done_cnt, 0);
        check("mid_rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        check("mid_rst_lu", {bus.lu_c, bus.lu_d, bus.lu_op}, 0);
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        m_last = 1; m_done = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_rst_rsp_valid", bus.rsp_valid, 0);
            check("post_rst_ready0", bus.req0_ready, 0);
            step();
        end

        // Contention with both valid held continuously: grants 0,1,0,1.
        bus.req0_valid = 1'b1; bus.req0_c = 2'b01; bus.req0_d = 2'b11; bus.req0_op = 2'd3;
        bus.req1_valid = 1'b1; bus.req1_c = 2'b10; bus.req1_d = 2'b00; bus.req1_op = 2'd1;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = m_grant(1'b1, 1'b1);
            check("cont_expected_grant", g, k % 2);
            check("cont_ready0", bus.req0_ready, g == 0);
            check("cont_ready1", bus.req1_ready, g == 1);
            step();
            check("cont_exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
            step();
            check("cont_rsp_f", bus.rsp_f, g ? 2'b01 : 2'b10);
            check("cont_rsp_id", bus.rsp_id, g);
            step();
            m_last = g;
            m_done = m_done + 1;
            check("cont_done", bus.done_cnt, m_done);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Saturation of the completion counter.
        for (int i = 0; i < 300; i++) begin
            rc0 = 2'($urandom); rd0 = 2'($urandom); ro0 = 2'($urandom);
            txn(1'b1, 1'b0, rc0, rd0, ro0, 2'b00, 2'b00, 2'd0, 0, lu_model(rc0, rd0, ro0));
        end
        check("sat_done_cnt", bus.done_cnt, DONE_MAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
